// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data memory arbiter.
// Requester indices and owner FIFO entry format.
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_AXI  = 1'b1
  } req_idx_t;

  typedef req_idx_t owner_entry_t;

  function automatic req_idx_t other_req(
    input req_idx_t i
  );
    return (i == REQ_CORE) ? REQ_AXI : REQ_CORE;
  endfunction

endpackage

// File: rtl/dmem_arb_owner_fifo.sv
// In-order owner queue: records which requester owns
// each outstanding memory access.
import dmem_arb_pkg::*;

module dmem_arb_owner_fifo #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  owner_entry_t push_data_i,
  input  logic         pop_i,
  output owner_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  owner_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory port between
// the core and the AXI adapter, with in-order response routing.
import dmem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    req_0_req_i,
  output logic                    req_0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   req_0_addr_i,
  input  logic                    req_0_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_0_be_i,
  input  logic [DATA_WIDTH-1:0]   req_0_wdata_i,
  output logic                    req_0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   req_0_rdata_o,

  input  logic                    req_1_req_i,
  output logic                    req_1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   req_1_addr_i,
  input  logic                    req_1_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_1_be_i,
  input  logic [DATA_WIDTH-1:0]   req_1_wdata_i,
  output logic                    req_1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   req_1_rdata_o,

  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  req_idx_t     sel;
  req_idx_t     last_q;
  req_idx_t     lock_idx_q;
  logic         lock_q;
  logic         err_q;
  logic         hs;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  owner_entry_t fifo_head;
  logic [CW-1:0] fifo_count;

  // A pending request stays locked so memory never sees it change.
  always_comb begin
    sel = REQ_CORE;
    unique case (1'b1)
      lock_q:
        sel = lock_idx_q;
      ~lock_q & req_0_req_i & req_1_req_i:
        sel = other_req(last_q);
      ~lock_q & ~req_0_req_i & req_1_req_i:
        sel = REQ_AXI;
      default:
        sel = REQ_CORE;
    endcase
  end

  assign mem_req_o = (req_0_req_i | req_1_req_i | lock_q)
                   & ~fifo_full;
  assign hs        = mem_req_o & mem_gnt_i;

  assign mem_addr_o  = (sel == REQ_AXI) ? req_1_addr_i
                                        : req_0_addr_i;
  assign mem_we_o    = (sel == REQ_AXI) ? req_1_we_i
                                        : req_0_we_i;
  assign mem_be_o    = (sel == REQ_AXI) ? req_1_be_i
                                        : req_0_be_i;
  assign mem_wdata_o = (sel == REQ_AXI) ? req_1_wdata_i
                                        : req_0_wdata_i;

  assign req_0_gnt_o = hs & (sel == REQ_CORE);
  assign req_1_gnt_o = hs & (sel == REQ_AXI);

  assign pop = mem_rvalid_i & ~fifo_empty;

  assign req_0_rvalid_o = pop & (fifo_head == REQ_CORE);
  assign req_1_rvalid_o = pop & (fifo_head == REQ_AXI);
  assign req_0_rdata_o  = mem_rdata_i;
  assign req_1_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= REQ_CORE;
      last_q     <= REQ_AXI;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        lock_q <= 1'b0;
        last_q <= sel;
      end else if (mem_req_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (mem_rvalid_i & fifo_empty) err_q <= 1'b1;
    end
  end

  dmem_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (hs),
    .push_data_i (sel),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign busy_o = (fifo_count != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: queue-based reference model,
// simple latency-configurable memory, directed scenarios.
module tb_data_mem_arbiter;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, req1 = 0;
  logic [31:0] a0 = 0, a1 = 0, wd0 = 0, wd1 = 0;
  logic        we0 = 0, we1 = 0;
  logic [3:0]  be0 = 4'hF, be1 = 4'hF;
  logic        mem_gnt_i = 0;
  logic        inj = 0;
  logic [31:0] inj_data = 32'h5A5A_5A5A;
  logic        rsp_valid = 0;
  logic [31:0] rsp_data = 0;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        req_0_gnt_o, req_1_gnt_o;
  logic        req_0_rvalid_o, req_1_rvalid_o;
  logic [31:0] req_0_rdata_o, req_1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        busy_o, err_o;

  assign mem_rvalid_i = rsp_valid | inj;
  assign mem_rdata_i  = rsp_valid ? rsp_data : inj_data;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_0_req_i(req0), .req_0_gnt_o(req_0_gnt_o),
    .req_0_addr_i(a0), .req_0_we_i(we0), .req_0_be_i(be0),
    .req_0_wdata_i(wd0), .req_0_rvalid_o(req_0_rvalid_o),
    .req_0_rdata_o(req_0_rdata_o),
    .req_1_req_i(req1), .req_1_gnt_o(req_1_gnt_o),
    .req_1_addr_i(a1), .req_1_we_i(we1), .req_1_be_i(be1),
    .req_1_wdata_i(wd1), .req_1_rvalid_o(req_1_rvalid_o),
    .req_1_rdata_o(req_1_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Memory: fixed latency, in-order, not affected by reset.
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t        rq[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] mem [logic [31:0]];

  always begin
    logic [31:0] d;
    @(posedge clk);
    if (rsp_valid && rq.size() > 0) rq.delete(0);
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        mem[mem_addr_o] = mem_wdata_o;
        d = 32'h0;
      end else begin
        d = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
      end
      rq.push_back('{d, cyc + lat});
    end
    cyc++;
    #1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = rq[0].data;
    end else begin
      rsp_valid = 1'b0;
    end
  end

  // Reference model: owner queue, last winner, pending owner.
  int oq[$];
  int m_last = 1;
  int m_pend = -1;
  bit m_err = 0;
  bit armed = 0;

  function automatic int m_sel();
    if (m_pend >= 0) return m_pend;
    if (req0 && req1) return 1 - m_last;
    return req1 ? 1 : 0;
  endfunction

  function automatic bit m_req();
    return (m_pend >= 0 || req0 || req1) && oq.size() < MO;
  endfunction

  always @(posedge clk) begin
    bit r;
    int s;
    r = m_req();
    s = m_sel();
    if (reset) begin
      oq.delete();
      m_last = 1;
      m_pend = -1;
      m_err  = 0;
      armed  = 1;
    end else if (armed) begin
      if (mem_rvalid_i) begin
        if (oq.size() > 0) oq.delete(0);
        else m_err = 1;
      end
      if (r && mem_gnt_i) begin
        oq.push_back(s);
        m_last = s;
        m_pend = -1;
      end else if (r) begin
        m_pend = s;
      end
    end
  end

  logic [31:0] got0[$];
  logic [31:0] got1[$];

  always @(negedge clk) begin
    bit r;
    int s;
    int h;
    if (armed) begin
      r = m_req();
      s = m_sel();
      h = (oq.size() > 0) ? oq[0] : -1;
      chk("mem_req", 32'(mem_req_o), 32'(r));
      chk("gnt0", 32'(req_0_gnt_o),
          32'(r && mem_gnt_i && s == 0));
      chk("gnt1", 32'(req_1_gnt_o),
          32'(r && mem_gnt_i && s == 1));
      if (r) begin
        chk("mem_addr", mem_addr_o, s == 1 ? a1 : a0);
        chk("mem_we", 32'(mem_we_o),
            32'(s == 1 ? we1 : we0));
        chk("mem_be", 32'(mem_be_o),
            32'(s == 1 ? be1 : be0));
        chk("mem_wdata", mem_wdata_o, s == 1 ? wd1 : wd0);
      end
      chk("rvalid0", 32'(req_0_rvalid_o),
          32'(mem_rvalid_i && h == 0));
      chk("rvalid1", 32'(req_1_rvalid_o),
          32'(mem_rvalid_i && h == 1));
      chk("rdata0", req_0_rdata_o, mem_rdata_i);
      chk("rdata1", req_1_rdata_o, mem_rdata_i);
      chk("busy", 32'(busy_o), 32'(oq.size() != 0));
      chk("err", 32'(err_o), 32'(m_err));
      if (req_0_rvalid_o) got0.push_back(req_0_rdata_o);
      if (req_1_rvalid_o) got1.push_back(req_1_rdata_o);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b1;
    req0 = 0; req1 = 0; mem_gnt_i = 0; inj = 0;
    nxt();
    reset = 1'b0;
  endtask

  int order[4];

  initial begin
    repeat (2) nxt();
    smp();
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);

    // Core-only write, immediate grant.
    nxt();
    reset = 0;
    req0 = 1; we0 = 1; a0 = 32'h10;
    wd0 = 32'hDEAD_DEAD; be0 = 4'hF; mem_gnt_i = 1;
    smp();
    chk("w_gnt0", 32'(req_0_gnt_o), 32'h1);
    chk("w_gnt1", 32'(req_1_gnt_o), 32'h0);
    nxt();
    req0 = 0; we0 = 0; mem_gnt_i = 0;
    smp();
    chk("w_rvalid0", 32'(req_0_rvalid_o), 32'h1);
    chk("w_rvalid1", 32'(req_1_rvalid_o), 32'h0);
    chk("w_stored", mem.exists(32'h10) ? mem[32'h10] : 32'h0,
        32'hDEAD_DEAD);

    // Both ports read every cycle: round-robin from core.
    do_reset();
    mem[32'h100] = 32'hA0A0_0001;
    mem[32'h200] = 32'hB0B0_0002;
    got0.delete();
    got1.delete();
    req0 = 1; a0 = 32'h100;
    req1 = 1; a1 = 32'h200;
    mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      smp();
      order[i] = req_1_gnt_o ? 1 : (req_0_gnt_o ? 0 : 9);
    end
    nxt();
    req0 = 0; req1 = 0; mem_gnt_i = 0;
    repeat (3) nxt();
    smp();
    chk("rr_0", 32'(order[0]), 32'd0);
    chk("rr_1", 32'(order[1]), 32'd1);
    chk("rr_2", 32'(order[2]), 32'd0);
    chk("rr_3", 32'(order[3]), 32'd1);
    chk("rr_n0", 32'(got0.size()), 32'd2);
    chk("rr_n1", 32'(got1.size()), 32'd2);
    foreach (got0[i]) chk("rr_d0", got0[i], 32'hA0A0_0001);
    foreach (got1[i]) chk("rr_d1", got1[i], 32'hB0B0_0002);

    // AXI held at memory while the core joins.
    nxt();
    req1 = 1; a1 = 32'h300; a0 = 32'h400;
    smp();
    chk("lk_addr0", mem_addr_o, 32'h300);
    chk("lk_gnt1a", 32'(req_1_gnt_o), 32'h0);
    nxt();
    req0 = 1;
    smp();
    chk("lk_addr1", mem_addr_o, 32'h300);
    chk("lk_gnt0a", 32'(req_0_gnt_o), 32'h0);
    nxt();
    smp();
    chk("lk_addr2", mem_addr_o, 32'h300);
    nxt();
    mem_gnt_i = 1;
    smp();
    chk("lk_gnt1", 32'(req_1_gnt_o), 32'h1);
    chk("lk_gnt0b", 32'(req_0_gnt_o), 32'h0);
    nxt();
    req1 = 0;
    smp();
    chk("lk_gnt0", 32'(req_0_gnt_o), 32'h1);
    chk("lk_addr3", mem_addr_o, 32'h400);
    nxt();
    req0 = 0; mem_gnt_i = 0;
    repeat (3) nxt();

    // Slow memory fills the owner FIFO.
    do_reset();
    lat = 4;
    got0.delete();
    req0 = 1; a0 = 32'h100; mem_gnt_i = 1;
    smp();
    chk("fl_g0", 32'(req_0_gnt_o), 32'h1);
    nxt();
    smp();
    chk("fl_g1", 32'(req_0_gnt_o), 32'h1);
    nxt();
    smp();
    chk("fl_req2", 32'(mem_req_o), 32'h0);
    chk("fl_busy", 32'(busy_o), 32'h1);
    nxt();
    smp();
    chk("fl_req3", 32'(mem_req_o), 32'h0);
    nxt();
    smp();
    chk("fl_req4", 32'(mem_req_o), 32'h0);
    chk("fl_rv4", 32'(req_0_rvalid_o), 32'h1);
    nxt();
    smp();
    chk("fl_req5", 32'(mem_req_o), 32'h1);
    chk("fl_rv5", 32'(req_0_rvalid_o), 32'h1);
    nxt();
    req0 = 0; mem_gnt_i = 0;
    repeat (6) nxt();
    smp();
    chk("fl_n", 32'(got0.size()), 32'd3);
    chk("fl_idle", 32'(busy_o), 32'h0);

    // Stray response sets a sticky error.
    nxt();
    inj = 1;
    smp();
    chk("st_rv0", 32'(req_0_rvalid_o), 32'h0);
    chk("st_rv1", 32'(req_1_rvalid_o), 32'h0);
    nxt();
    inj = 0;
    smp();
    chk("st_err1", 32'(err_o), 32'h1);
    nxt();
    smp();
    chk("st_err2", 32'(err_o), 32'h1);
    do_reset();
    smp();
    chk("st_clr", 32'(err_o), 32'h0);

    // Reset with two accesses outstanding.
    nxt();
    req0 = 1; a0 = 32'h200; mem_gnt_i = 1;
    nxt();
    nxt();
    req0 = 0; mem_gnt_i = 0; reset = 1;
    smp();
    chk("mr_busy1", 32'(busy_o), 32'h1);
    nxt();
    reset = 0;
    smp();
    chk("mr_busy0", 32'(busy_o), 32'h0);
    chk("mr_err0", 32'(err_o), 32'h0);
    repeat (3) nxt();
    smp();
    chk("mr_err1", 32'(err_o), 32'h1);
    repeat (2) nxt();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
